// File: rtl/addsub_selftest_driver_if.sv
// Bus between the self-test driver and the combinational add/sub under test.
// The master end drives operands and mode; the slave end returns the result.
interface addsub_selftest_driver_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] dut_a;
   logic [WIDTH-1:0] dut_b;
   logic             dut_c;
   logic [WIDTH-1:0] dut_s;

   modport master (output dut_a, output dut_b, output dut_c, input dut_s);
   modport slave  (input dut_a, input dut_b, input dut_c, output dut_s);
endinterface

// File: rtl/addsub_selftest_driver.sv
// Exhaustive stimulus sweep over {c, a, b} for a combinational add/sub, with a
// built-in golden model, mismatch counter and first-failure capture.
module addsub_selftest_driver #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   addsub_selftest_driver_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [2*WIDTH+1:0]    fail_count,
   output logic                  first_fail_valid,
   output logic [2*WIDTH:0]      first_fail_vec,
   output logic [WIDTH-1:0]      first_fail_s
);

   localparam int VW = 2*WIDTH + 1;
   localparam int FW = 2*WIDTH + 2;
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0]    SETTLE_RELOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [VW-1:0]    LAST_VEC      = '1;
   localparam logic [WIDTH-1:0] ONE_W         = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [VW-1:0]    r_vec;
   logic [CW-1:0]    r_settle;
   logic [FW-1:0]    r_fail_count;
   logic             r_ff_valid;
   logic [VW-1:0]    r_ff_vec;
   logic [WIDTH-1:0] r_ff_s;

   logic             w_load;
   logic             w_check;
   logic             w_last;
   logic             w_mismatch;
   logic             w_c;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_expected;

   assign w_c = r_vec[VW-1];
   assign w_a = r_vec[2*WIDTH-1:WIDTH];
   assign w_b = r_vec[WIDTH-1:0];

   // Golden model: subtract is a + ~b + 1; carry-out falls off the top.
   assign w_expected = w_c ? (w_a + ~w_b + ONE_W) : (w_a + w_b);
   assign w_last     = (r_vec == LAST_VEC);
   assign w_mismatch = (bus.dut_s != w_expected);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_check     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (r_settle == '0) begin
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            w_check     = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_SETTLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec        <= '0;
         r_settle     <= '0;
         r_fail_count <= '0;
         r_ff_valid   <= 1'b0;
         r_ff_vec     <= '0;
         r_ff_s       <= '0;
      end else if (w_load) begin
         r_vec        <= '0;
         r_settle     <= SETTLE_RELOAD;
         r_fail_count <= '0;
         r_ff_valid   <= 1'b0;
         r_ff_vec     <= '0;
         r_ff_s       <= '0;
      end else if (w_check) begin
         if (w_mismatch) begin
            r_fail_count <= r_fail_count + FW'(1);
            if (!r_ff_valid) begin
               r_ff_valid <= 1'b1;
               r_ff_vec   <= r_vec;
               r_ff_s     <= bus.dut_s;
            end
         end
         if (!w_last) begin
            r_vec    <= r_vec + VW'(1);
            r_settle <= SETTLE_RELOAD;
         end
      end else if (r_state == S_SETTLE && r_settle != '0) begin
         r_settle <= r_settle - CW'(1);
      end
   end

   assign bus.dut_a = w_a;
   assign bus.dut_b = w_b;
   assign bus.dut_c = w_c;

   assign busy             = (r_state == S_SETTLE) || (r_state == S_CHECK);
   assign done             = (r_state == S_DONE);
   assign pass             = done && (r_fail_count == '0);
   assign fail_count       = r_fail_count;
   assign first_fail_valid = r_ff_valid;
   assign first_fail_vec   = r_ff_vec;
   assign first_fail_s     = r_ff_s;

endmodule

// File: tb/tb_addsub_selftest_driver.sv
// Bench for addsub_selftest_driver: attaches a lab add/sub with selectable faults
// and checks every cycle against a time-based sweep model plus literal expectations.
module tb_addsub_selftest_driver;

   localparam int W   = 4;
   localparam int SC  = 2;
   localparam int VW  = 2*W + 1;
   localparam int FW  = 2*W + 2;
   localparam int NV  = 1 << VW;
   localparam int PER = SC + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   int   mode  = 0;   // 0 correct, 1 S[0] stuck at 0, 2 ignores C

   logic          busy, done, pass, ffv;
   logic [FW-1:0] fail_count;
   logic [VW-1:0] ffvec;
   logic [W-1:0]  ffs;

   int unsigned cyc = 0;
   int          n_total = 0;
   int          n_pass  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   addsub_selftest_driver_if #(.WIDTH(W)) bus ();

   addsub_selftest_driver #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .bus              (bus.master),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .fail_count       (fail_count),
      .first_fail_valid (ffv),
      .first_fail_vec   (ffvec),
      .first_fail_s     (ffs)
   );

   function automatic logic [W-1:0] lab_fn(int md, logic c, logic [W-1:0] a, logic [W-1:0] b);
      logic [W-1:0] r;
      case (md)
         1:       r = (c ? a - b : a + b) & ~W'(1);
         2:       r = a + b;
         default: r = c ? a - b : a + b;
      endcase
      return r;
   endfunction

   always_comb bus.dut_s = lab_fn(mode, bus.dut_c, bus.dut_a, bus.dut_b);

   // Sweep model driven by elapsed cycles since the accepted start edge.
   typedef struct packed {
      bit            run;
      bit            fin;
      int            t;
      int            fails;
      bit            ffv;
      logic [VW-1:0] ffvec;
      logic [W-1:0]  ffs;
      logic [VW-1:0] vec;
   } model_t;

   model_t m;

   function automatic model_t step(model_t cur, logic st, int md);
      model_t       n = cur;
      int           v;
      logic [VW-1:0] vv;
      logic [W-1:0] s_got, s_exp;
      if (!cur.run) begin
         if (st) begin
            n = '0;
            n.run = 1'b1;
         end
      end else begin
         v  = cur.t / PER;
         vv = VW'(v);
         if (cur.t % PER == SC) begin
            s_got = lab_fn(md, vv[VW-1], vv[2*W-1:W], vv[W-1:0]);
            s_exp = vv[VW-1] ? vv[2*W-1:W] - vv[W-1:0] : vv[2*W-1:W] + vv[W-1:0];
            if (s_got != s_exp) begin
               n.fails = cur.fails + 1;
               if (!cur.ffv) begin
                  n.ffv   = 1'b1;
                  n.ffvec = vv;
                  n.ffs   = s_got;
               end
            end
            if (v == NV - 1) begin
               n.run = 1'b0;
               n.fin = 1'b1;
            end
         end
         n.t = cur.t + 1;
         if (n.run) n.vec = VW'(n.t / PER);
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= step(m, start, mode);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      else n_pass++;
   endtask

   task automatic do_start(output int unsigned t0);
      @(posedge clk); #3 start = 1'b1;
      @(posedge clk); #3 start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(output int unsigned t_end);
      int k = 0;
      while (!done && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_timeout", {63'd0, done}, 64'd1);
      t_end = cyc;
   endtask

   int unsigned t0, t1;
   int          k;

   initial begin
      fork
         begin : seq
            #3;
            chk("reset_outputs", {busy, done, pass, fail_count, ffv, ffvec, ffs,
                                  bus.dut_c, bus.dut_a, bus.dut_b}, 64'd0);
            @(posedge clk); #3 rst_n = 1'b1;
            while (cyc < 8) @(posedge clk);
            #3;
            chk("idle_not_busy", {62'd0, busy, done}, 64'd0);

            // Correct DUT, busy start pulses ignored
            mode = 0;
            do_start(t0);
            chk("busy_after_start", {63'd0, busy}, 64'd1);
            chk("b_step0", {60'd0, bus.dut_b}, 64'd0);
            repeat (3) @(posedge clk); #1;
            chk("b_step1", {60'd0, bus.dut_b}, 64'd1);
            repeat (3) @(posedge clk); #1;
            chk("b_step2", {60'd0, bus.dut_b}, 64'd2);
            @(posedge clk); #2 start = 1'b1;
            @(posedge clk); #2 start = 1'b0;
            k = 0;
            while ({bus.dut_c, bus.dut_a, bus.dut_b} != 9'h100 && k < 2000) begin
               @(posedge clk); #1;
               k++;
            end
            chk("spot_vec100", {55'd0, bus.dut_c, bus.dut_a, bus.dut_b}, 64'h100);
            chk("spot_s", {60'd0, bus.dut_s}, 64'd0);
            repeat (3) @(posedge clk); #1;
            chk("spot_no_fail", {54'd0, fail_count}, 64'd0);
            @(posedge clk); #2 start = 1'b1;
            @(posedge clk); #2 start = 1'b0;
            wait_done(t1);
            chk("sweep_cycles", 64'(t1 - t0), 64'd1536);
            chk("good_result", {busy, done, pass, fail_count, ffv}, {3'b011, 10'd0, 1'b0});

            // S[0] stuck at 0
            mode = 1;
            do_start(t0);
            wait_done(t1);
            chk("stuck_fail_count", {54'd0, fail_count}, 64'd256);
            chk("stuck_first", {ffv, ffvec, ffs, pass}, {1'b1, 9'h001, 4'b0000, 1'b0});

            // Restart from DONE after a failing run clears results
            mode = 2;
            do_start(t0);
            chk("restart_cleared", {pass, fail_count, ffv, ffvec, ffs,
                                    bus.dut_c, bus.dut_a, bus.dut_b}, 64'd0);
            wait_done(t1);
            chk("noc_fail_count", {54'd0, fail_count}, 64'd224);
            chk("noc_first", {ffv, ffvec, ffs}, {1'b1, 9'h101, 4'b0001});

            // Async reset mid-sweep, then a clean full sweep
            mode = 0;
            do_start(t0);
            repeat (690) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("async_reset", {busy, done, pass, fail_count, ffv, ffvec, ffs,
                                bus.dut_c, bus.dut_a, bus.dut_b}, 64'd0);
            @(posedge clk); #3 rst_n = 1'b1;
            do_start(t0);
            wait_done(t1);
            chk("post_reset_cycles", 64'(t1 - t0), 64'd1536);
            chk("post_reset_result", {done, pass, fail_count, ffv}, {2'b11, 10'd0, 1'b0});

            // start held high: one cycle in DONE, then restart
            mode = 1;
            @(posedge clk); #3 start = 1'b1;
            @(posedge clk); #1;
            chk("held_busy", {63'd0, busy}, 64'd1);
            wait_done(t1);
            @(posedge clk); #1;
            chk("held_retrigger", {busy, done, fail_count, bus.dut_c, bus.dut_a, bus.dut_b},
                {2'b10, 10'd0, 9'h000});
            #2 start = 1'b0;
            repeat (20) @(posedge clk);
         end
         begin : cmp
            forever begin
               @(negedge clk);
               chk("cycle_model",
                   {28'd0, busy, done, pass, fail_count, ffv, ffvec, ffs,
                    bus.dut_c, bus.dut_a, bus.dut_b},
                   {28'd0, m.run, m.fin, m.fin && (m.fails == 0), FW'(m.fails),
                    m.ffv, m.ffvec, m.ffs, m.vec});
            end
         end
      join_any
      disable fork;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/addsub_selftest_driver.md
Name: addsub_selftest_driver

Overview:
- Sequential stimulus generator and checker: the driving end of the 4-bit ripple-carry adder/subtractor interface (A, B, C in; S out).
- Sweeps every {C, A, B} combination into a combinational add/sub DUT, waits a settle interval, compares S against an internal golden model, and counts mismatches.
- Used as an on-board self-test wrapper around the add/sub lab top, and as a reusable checker in simulation.

Parameters:
- WIDTH, 4, operand/result width of the DUT.
- SETTLE_CYCLES, 2, cycles each vector is held before S is sampled; legal range is 1 or more (0 is illegal).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE and DONE only.
- dut_a  output  WIDTH  operand A to DUT (registered).
- dut_b  output  WIDTH  operand B to DUT (registered).
- dut_c  output  1  mode to DUT: 0 = add, 1 = subtract (registered).
- dut_s  input  WIDTH  DUT result.
- busy  output  1  high while a sweep runs (SETTLE/CHECK).
- done  output  1  high in DONE.
- pass  output  1  high in DONE when fail_count == 0.
- fail_count  output  2*WIDTH+2  number of mismatching vectors.
- first_fail_valid  output  1  at least one mismatch captured this sweep.
- first_fail_vec  output  2*WIDTH+1  {c, a, b} of the first mismatch.
- first_fail_s  output  WIDTH  dut_s observed at the first mismatch.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - All outputs and internal counters are cleared to 0.
  - Reset mid-sweep aborts immediately; no partial result is retained.
- Vector counter vec, width 2*WIDTH+1, is ordered {c, a, b} with b as the LSBs.
  - dut_c/dut_a/dut_b are driven directly from registered vec.
  - Last vector is all ones, so there are 2^(2*WIDTH+1) vectors (512 by default).
- Golden model, computed mod 2^WIDTH:
  - c = 0: expected = a + b.
  - c = 1: expected = a + ~b + 1 (that is, a − b).
  - Carry-out is discarded.
- State machine: IDLE, SETTLE, CHECK, DONE.
  - IDLE:
    - busy = done = 0.
    - On start = 1: vec <= 0, fail_count <= 0, first_fail_* cleared, settle counter <= SETTLE_CYCLES−1, go to SETTLE.
  - SETTLE:
    - busy = 1; the current vector is held.
    - Decrement the settle counter; when it is 0, go to CHECK.
    - SETTLE lasts exactly SETTLE_CYCLES cycles.
  - CHECK (1 cycle):
    - Compare dut_s with expected.
    - On mismatch: fail_count increments. If first_fail_valid = 0, capture first_fail_vec = vec, first_fail_s = dut_s, first_fail_valid = 1.
    - If vec is the last vector, go to DONE.
    - Otherwise: vec++, reload the settle counter, go to SETTLE.
  - DONE:
    - busy = 0, done = 1, pass = (fail_count == 0).
    - Results and the last vector are held.
    - start = 1 restarts exactly as from IDLE (counts cleared).
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - With the start edge at cycle k, new vectors appear at k+1, k+1+(SETTLE_CYCLES+1), and so on.
  - DONE is entered 2^(2*WIDTH+1)·(SETTLE_CYCLES+1) cycles after the start edge: 1536 by default.
- Boundary cases:
  - start while busy: ignored.
  - start held high continuously: re-triggers only from DONE (one cycle in DONE, then restart).
  - fail_count width holds the full vector count, so it never overflows and needs no saturation.
  - dut_s is sampled only in CHECK; changes during SETTLE are ignored.

Test Plan:
- Correct add/sub model attached, SETTLE_CYCLES=2, start pulsed at cycle 10 -> busy 1 from cycle 11; done=1, pass=1, fail_count=0, first_fail_valid=0 after 1536 cycles; dut_b steps 0,1,2… every 3 cycles.
- DUT with S[0] stuck at 0 -> fail_count=256, first_fail_vec=9'h001, first_fail_s=4'b0000, pass=0.
- DUT that ignores C (always adds) -> fail_count=224 (all b except 0 and 8 in subtract mode), first_fail_vec=9'h101, first_fail_s=4'b0001.
- Spot check vector A=0, B=0, C=1 (vec=9'h100) with correct DUT -> expected S=4'b0000, no mismatch counted.
- rst_n pulled low at cycle 700 mid-sweep -> all outputs 0 and IDLE immediately (asynchronously); a new start performs a full 1536-cycle sweep with clean counts.
- start re-pulsed during busy -> no effect on vec or timing; start pulsed in DONE after a failing run -> fail_count, first_fail_* and pass cleared, sweep restarts from vec=0.
